// File: rtl/btn_evt_pkg.sv
// Shared types for the button event arbiter: per-button FSM states and event type codes.
package btn_evt_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HELD      = 2'd1,
      LONG_DONE = 2'd2
   } btn_state_e;

   localparam logic EVT_SHORT = 1'b0;
   localparam logic EVT_LONG  = 1'b1;

endpackage

// File: rtl/btn_press_fsm.sv
// One button press classifier; raises a one-cycle event toward the arbiter's pending store.
// With BTN_LONG_PRESS_EN the event fires at release (short) or at the hold threshold (long).
//
// state     | meaning
// IDLE      | button released, waiting for a press
// HELD      | button pressed, counting hold samples
// LONG_DONE | long event already raised, waiting for release
module btn_press_fsm
   import btn_evt_pkg::*;
`ifdef BTN_LONG_PRESS_EN
#(
   parameter int LONG_CYCLES = 1000
)
`endif
(
   input  logic clk,
   input  logic reset_n,
   input  logic level,
`ifdef BTN_LONG_PRESS_EN
   output logic evt_type,
`endif
   output logic evt_raise
);

   btn_state_e state_q, state_d;

`ifdef BTN_LONG_PRESS_EN
   localparam int CW = $clog2(LONG_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // The press sample counts as the first high sample, so the threshold compares against LONG_CYCLES-1.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      evt_raise = 1'b0;
      evt_type  = EVT_SHORT;
      case (state_q)
         IDLE: begin
            if (level) begin
               state_d = HELD;
               cnt_d   = CW'(1);
            end
         end
         HELD: begin
            if (!level) begin
               evt_raise = 1'b1;
               state_d   = IDLE;
            end else if (cnt_q == CW'(LONG_CYCLES - 1)) begin
               evt_raise = 1'b1;
               evt_type  = EVT_LONG;
               state_d   = LONG_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         LONG_DONE: begin
            if (!level) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   always_comb begin
      state_d   = state_q;
      evt_raise = 1'b0;
      case (state_q)
         IDLE: begin
            if (level) begin
               evt_raise = 1'b1;
               state_d   = HELD;
            end
         end
         HELD: begin
            if (!level) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end
`endif

endmodule

// File: rtl/btn_event_arbiter.sv
// Per-button press classifiers feeding a one-deep pending store, round-robin grant and a
// valid/ready output register. Long-press support is built only when BTN_LONG_PRESS_EN is defined.
module btn_event_arbiter
   import btn_evt_pkg::*;
#(
   parameter int N_BTN       = 4,
   parameter int LONG_CYCLES = 1000
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_BTN-1:0]         btn_level,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [$clog2(N_BTN)-1:0] evt_id,
   output logic                     evt_long,
   output logic                     evt_overrun
);

   localparam int IW = $clog2(N_BTN);

   if (N_BTN < 2 || LONG_CYCLES < 2) begin : g_bad_cfg
      $error("btn_event_arbiter: N_BTN and LONG_CYCLES must both be >= 2");
   end

   logic [N_BTN-1:0] raise;
   logic [N_BTN-1:0] pend_q, pend_d;
   logic [IW-1:0]    ptr_q, ptr_d, id_q, id_d, grant, cand;
   logic             valid_q, valid_d, ovr_q, ovr_d, found, load;

`ifdef BTN_LONG_PRESS_EN
   logic [N_BTN-1:0] rtype, type_q, type_d;
   logic             long_q, long_d;
`endif

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_press_fsm
`ifdef BTN_LONG_PRESS_EN
         #(.LONG_CYCLES(LONG_CYCLES))
`endif
      u_fsm (
         .clk      (clk),
         .reset_n  (reset_n),
         .level    (btn_level[i]),
`ifdef BTN_LONG_PRESS_EN
         .evt_type (rtype[i]),
`endif
         .evt_raise(raise[i])
      );
   end

   // First pending button at or after the pointer, wrapping.
   always_comb begin
      found = 1'b0;
      grant = '0;
      cand  = '0;
      for (int j = 0; j < N_BTN; j++) begin
         cand = IW'((int'(ptr_q) + j) % N_BTN);
         if (!found && pend_q[cand]) begin
            found = 1'b1;
            grant = cand;
         end
      end
   end

   always_comb begin
      load    = !valid_q || evt_ready;
      valid_d = valid_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      pend_d  = pend_q;
      ovr_d   = ovr_q;
`ifdef BTN_LONG_PRESS_EN
      long_d  = long_q;
      type_d  = type_q;
`endif
      if (load) begin
         valid_d = found;
         if (found) begin
            id_d          = grant;
            pend_d[grant] = 1'b0;
            ptr_d         = (grant == IW'(N_BTN - 1)) ? '0 : grant + IW'(1);
`ifdef BTN_LONG_PRESS_EN
            long_d        = type_q[grant];
`endif
         end
      end
      // pend_d already reflects a same-cycle clear, so a raise into a draining slot is kept.
      for (int i = 0; i < N_BTN; i++) begin
         if (raise[i]) begin
            if (pend_q[i] && pend_d[i]) begin
               ovr_d = 1'b1;
            end else begin
               pend_d[i] = 1'b1;
`ifdef BTN_LONG_PRESS_EN
               type_d[i] = rtype[i];
`endif
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         id_q    <= '0;
         ptr_q   <= '0;
         pend_q  <= '0;
         ovr_q   <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
         long_q  <= 1'b0;
         type_q  <= '0;
`endif
      end else begin
         valid_q <= valid_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
`ifdef BTN_LONG_PRESS_EN
         long_q  <= long_d;
         type_q  <= type_d;
`endif
      end
   end

   assign evt_valid   = valid_q;
   assign evt_id      = id_q;
   assign evt_overrun = ovr_q;
`ifdef BTN_LONG_PRESS_EN
   assign evt_long    = long_q;
`else
   assign evt_long    = EVT_SHORT;
`endif

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Scoreboard bench for btn_event_arbiter (N_BTN=4, LONG_CYCLES=8); expectations follow BTN_LONG_PRESS_EN.
module tb_btn_event_arbiter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] btn_level;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_id;
   logic       evt_long;
   logic       evt_overrun;

   btn_event_arbiter #(.N_BTN(4), .LONG_CYCLES(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn_level  (btn_level),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_id     (evt_id),
      .evt_long   (evt_long),
      .evt_overrun(evt_overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] id;
      logic       lng;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   logic hold_prev = 1'b0;
   logic [1:0] prev_id;
   logic prev_long;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input int id, input int lng);
      exp_t e;
      e.id  = 2'(id);
      e.lng = 1'(lng);
      expq.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tap(input int b, input int hold);
      btn_level[b] = 1'b1;
      tick(hold);
      btn_level[b] = 1'b0;
      tick(2);
   endtask

   // Monitor: pops on every handshake and checks that a stalled event stays put.
   always @(negedge clk) begin
      if (!reset_n) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("stall_valid", evt_valid, 1);
            chk("stall_id", evt_id, prev_id);
            chk("stall_long", evt_long, prev_long);
         end
         if (evt_valid && evt_ready) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_evt: got id=%0d long=%0d expected none", evt_id, evt_long);
            end else begin
               mon_e = expq.pop_front();
               chk("evt_id", evt_id, mon_e.id);
               chk("evt_long", evt_long, mon_e.lng);
            end
         end
         hold_prev = evt_valid && !evt_ready;
         prev_id   = evt_id;
         prev_long = evt_long;
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      btn_level = '0;
      evt_ready = 1'b1;
      #2;
      chk("rst_valid", evt_valid, 0);
      chk("rst_id", evt_id, 0);
      chk("rst_long", evt_long, 0);
      chk("rst_ovr", evt_overrun, 0);
      tick(2);
      reset_n = 1'b1;
      tick(2);

      // short press on btn0
`ifdef BTN_LONG_PRESS_EN
      btn_level[0] = 1'b1;
      tick(3);
      btn_level[0] = 1'b0;
      push_exp(0, 0);
      tick(1);
      chk("t2_edge_k", evt_valid, 0);
      tick(1);
      chk("t2_edge_k1", evt_valid, 1);
      chk("t2_id", evt_id, 0);
      tick(1);
      chk("t2_edge_k2", evt_valid, 0);
`else
      btn_level[0] = 1'b1;
      push_exp(0, 0);
      tick(1);
      chk("t2_edge_k", evt_valid, 0);
      tick(1);
      chk("t2_edge_k1", evt_valid, 1);
      chk("t2_id", evt_id, 0);
      tick(1);
      chk("t2_edge_k2", evt_valid, 0);
      btn_level[0] = 1'b0;
      tick(3);
      chk("t2_release", evt_valid, 0);
`endif

      // 20-cycle hold on btn2
      btn_level[2] = 1'b1;
`ifdef BTN_LONG_PRESS_EN
      push_exp(2, 1);
      tick(7);
      tick(1);
      chk("t3_edge8", evt_valid, 0);
      tick(1);
      chk("t3_edge9", evt_valid, 1);
      chk("t3_id", evt_id, 2);
      chk("t3_long", evt_long, 1);
      tick(1);
      chk("t3_drain", evt_valid, 0);
      tick(10);
`else
      push_exp(2, 0);
      tick(1);
      chk("t3_edge1", evt_valid, 0);
      tick(1);
      chk("t3_edge2", evt_valid, 1);
      chk("t3_id", evt_id, 2);
      chk("t3_long", evt_long, 0);
      tick(18);
      chk("t3_hold", evt_valid, 0);
`endif
      btn_level[2] = 1'b0;
      tick(4);
      chk("t3_release", evt_valid, 0);

      // round robin: serve btn1 first, then btn1+btn3 together
      push_exp(1, 0);
      tap(1, 2);
      tick(2);
      chk("t4_drain", evt_valid, 0);
      evt_ready = 1'b0;
      push_exp(3, 0);
      push_exp(1, 0);
      btn_level[1] = 1'b1;
      btn_level[3] = 1'b1;
`ifdef BTN_LONG_PRESS_EN
      tick(2);
      btn_level[1] = 1'b0;
      btn_level[3] = 1'b0;
`endif
      tick(1);
      tick(1);
      chk("t4_valid", evt_valid, 1);
      chk("t4_id_first", evt_id, 3);
      tick(5);
      chk("t4_id_stall", evt_id, 3);
      evt_ready = 1'b1;
      tick(1);
      chk("t4_second_valid", evt_valid, 1);
      chk("t4_second_id", evt_id, 1);
      tick(1);
      chk("t4_empty", evt_valid, 0);
      btn_level = '0;
      tick(3);

      // overrun: output busy with btn1, btn0 pressed twice
      evt_ready = 1'b0;
      push_exp(1, 0);
      tap(1, 2);
      push_exp(0, 0);
      tap(0, 2);
      chk("t5_ovr_before", evt_overrun, 0);
      tap(0, 2);
      chk("t5_ovr_set", evt_overrun, 1);
      evt_ready = 1'b1;
      tick(4);
      chk("t5_drained", evt_valid, 0);
      chk("t5_ovr_sticky", evt_overrun, 1);
      chk("t5_queue", expq.size(), 0);

      // asynchronous reset while an event is presented and another is pending
      evt_ready = 1'b0;
      btn_level[2] = 1'b1;
      btn_level[3] = 1'b1;
`ifdef BTN_LONG_PRESS_EN
      tick(2);
      btn_level = '0;
`endif
      tick(3);
      chk("t1_pre_valid", evt_valid, 1);
      #2;
      reset_n   = 1'b0;
      btn_level = '0;
      #1;
      chk("t1_async_valid", evt_valid, 0);
      chk("t1_async_id", evt_id, 0);
      chk("t1_async_long", evt_long, 0);
      chk("t1_async_ovr", evt_overrun, 0);
      tick(2);
      reset_n   = 1'b1;
      evt_ready = 1'b1;
      tick(5);
      chk("t1_pending_lost", evt_valid, 0);

      chk("final_queue", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
